// File: rtl/note_sequencer_if.sv
// Note RAM port: the sequencer is master, the RAM is slave.
// Read data is expected one cycle after the address.
interface note_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 7
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/note_sequencer.sv
// Record/playback sequencer for a single-port note RAM.
// Entries are {duration, note}; playback holds each note for beats*TICK_DIV cycles.
module note_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int NOTE_W   = 4,
    parameter int DUR_W    = 3,
    parameter int TICK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    note_sequencer_if.master    io_mem,
    input  logic                i_rec_req,
    input  logic [NOTE_W-1:0]   i_note_in,
    input  logic [DUR_W-1:0]    i_dur_in,
    input  logic                i_play_start,
    input  logic                i_play_stop,
    input  logic                i_loop_en,
    input  logic                i_clear,
    output logic                o_rec_ack,
    output logic [NOTE_W-1:0]   o_tone_note,
    output logic                o_tone_en,
    output logic                o_busy,
    output logic                o_full,
    output logic [ADDR_W:0]     o_note_count,
    output logic [ADDR_W-1:0]   o_play_idx
);
    localparam int DW = DUR_W + NOTE_W;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_FETCH, S_LATCH, S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [DW-1:0]     r_wdata;
    logic [NOTE_W-1:0] r_note;
    logic              r_tone_en;
    logic [DUR_W-1:0]  r_beats;
    logic [TW-1:0]     r_tick;

    logic              w_busy;
    logic              w_full;
    logic              w_stop;
    logic              w_play_ok;
    logic              w_rec_ok;
    logic              w_last_beat;
    logic              w_more;
    logic [DUR_W-1:0]  w_rd_dur;
    logic [DUR_W-1:0]  w_rd_beats;

    assign w_busy      = (r_state == S_FETCH) || (r_state == S_LATCH) ||
                         (r_state == S_HOLD);
    assign w_full      = r_count[ADDR_W];
    assign w_stop      = w_busy && i_play_stop;
    assign w_play_ok   = i_play_start && (r_count != '0);
    assign w_rec_ok    = i_rec_req && !w_full && !w_play_ok;
    assign w_last_beat = (r_tick == '0) && (r_beats == DUR_W'(1));
    assign w_more      = ({1'b0, r_idx} + (ADDR_W+1)'(1)) < r_count;
    assign w_rd_dur    = io_mem.mem_rdata[DW-1:NOTE_W];
    // A stored duration of 0 still sounds for one beat.
    assign w_rd_beats  = (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_clear)        w_next = S_IDLE;
                else if (w_play_ok) w_next = S_FETCH;
                else if (w_rec_ok)  w_next = S_WRITE;
            end
            S_WRITE: w_next = S_IDLE;
            S_FETCH: w_next = i_play_stop ? S_IDLE : S_LATCH;
            S_LATCH: w_next = i_play_stop ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (i_play_stop)
                    w_next = S_IDLE;
                else if (w_last_beat)
                    w_next = (w_more || i_loop_en) ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        io_mem.mem_we    = (r_state == S_WRITE);
        io_mem.mem_addr  = (r_state == S_WRITE) ? r_count[ADDR_W-1:0] : r_idx;
        io_mem.mem_wdata = r_wdata;
        o_rec_ack        = (r_state == S_WRITE);
        o_busy           = w_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_note    <= '0;
            r_tone_en <= 1'b0;
            r_beats   <= '0;
            r_tick    <= TICK_LOAD;
        end else if (w_stop) begin
            r_tone_en <= 1'b0;
            r_idx     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_clear)        r_count <= '0;
                    else if (w_play_ok) r_idx   <= '0;
                    else if (w_rec_ok)  r_wdata <= {i_dur_in, i_note_in};
                end
                S_WRITE: r_count <= r_count + 1'b1;
                S_LATCH: begin
                    r_note    <= io_mem.mem_rdata[NOTE_W-1:0];
                    r_beats   <= w_rd_beats;
                    r_tick    <= TICK_LOAD;
                    r_tone_en <= 1'b1;
                end
                S_HOLD: begin
                    if (r_tick == '0) begin
                        r_tick  <= TICK_LOAD;
                        r_beats <= r_beats - 1'b1;
                    end else begin
                        r_tick  <= r_tick - 1'b1;
                    end
                    // End of the note: advance, wrap, or finish.
                    if (w_last_beat) begin
                        if (w_more) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (i_loop_en) begin
                            r_idx <= '0;
                        end else begin
                            r_idx     <= '0;
                            r_tone_en <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tone_note  = r_note;
    assign o_tone_en    = r_tone_en;
    assign o_full       = w_full;
    assign o_note_count = r_count;
    assign o_play_idx   = r_idx;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a behavioural note-list model.
// Expected writes and playback cycles are queued at issue and checked by a monitor.
module tb_note_sequencer;
    localparam int ADDR_W = 2;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 3;
    localparam int TICK   = 4;
    localparam int DW     = DUR_W + NOTE_W;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_rec_req = 1'b0;
    logic [NOTE_W-1:0] i_note_in = '0;
    logic [DUR_W-1:0]  i_dur_in = '0;
    logic              i_play_start = 1'b0;
    logic              i_play_stop = 1'b0;
    logic              i_loop_en = 1'b0;
    logic              i_clear = 1'b0;
    logic              o_rec_ack;
    logic [NOTE_W-1:0] o_tone_note;
    logic              o_tone_en;
    logic              o_busy;
    logic              o_full;
    logic [ADDR_W:0]   o_note_count;
    logic [ADDR_W-1:0] o_play_idx;

    note_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) bus ();

    note_sequencer #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TICK)
    ) dut (
        .clk(clk), .reset(reset), .io_mem(bus.master),
        .i_rec_req(i_rec_req), .i_note_in(i_note_in), .i_dur_in(i_dur_in),
        .i_play_start(i_play_start), .i_play_stop(i_play_stop),
        .i_loop_en(i_loop_en), .i_clear(i_clear),
        .o_rec_ack(o_rec_ack), .o_tone_note(o_tone_note),
        .o_tone_en(o_tone_en), .o_busy(o_busy), .o_full(o_full),
        .o_note_count(o_note_count), .o_play_idx(o_play_idx)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [CAP];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { bit en; int note; int idx; } tr_t;
    wr_t wq[$];
    tr_t tq[$];

    int n_checks = 0;
    int n_err = 0;
    int n_we = 0;
    int exp_we = 0;
    int m_count = 0;
    int m_last = 0;
    int m_note[CAP];
    int m_dur[CAP];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_we || o_rec_ack)
                chk("rec_ack", int'(o_rec_ack), int'(bus.mem_we));
            if (bus.mem_we) begin
                n_we++;
                chk("write_expected", int'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("mem_addr", int'(bus.mem_addr), w.addr);
                    chk("mem_wdata", int'(bus.mem_wdata), w.data);
                end
            end
            if (o_busy || o_tone_en) begin
                chk("play_expected", int'(tq.size() != 0), 1);
                if (tq.size() != 0) begin
                    tr_t t;
                    t = tq.pop_front();
                    chk("tone_en", int'(o_tone_en), int'(t.en));
                    chk("tone_note", int'(o_tone_note), t.note);
                    chk("play_idx", int'(o_play_idx), t.idx);
                end
            end
        end
    end

    // Reference: each entry is FETCH, LATCH, then max(dur,1)*TICK hold cycles.
    function automatic void build(input bit lp, input int lim);
        int idx;
        int n;
        int hold;
        int last;
        bit en;
        bit stop;
        idx = 0; n = 0; en = 0; stop = 0; last = m_last;
        while (!stop) begin
            hold = ((m_dur[idx] == 0) ? 1 : m_dur[idx]) * TICK;
            for (int ph = 0; ph < 2 + hold; ph++) begin
                if (lim >= 0 && n >= lim) begin
                    stop = 1;
                    break;
                end
                if (ph == 2) begin
                    en = 1;
                    last = m_note[idx];
                end
                tq.push_back('{en, last, idx});
                n++;
            end
            if (!stop) begin
                idx++;
                if (idx >= m_count) begin
                    if (lp) idx = 0;
                    else stop = 1;
                end
            end
        end
        m_last = last;
    endfunction

    task automatic rec(input int note, input int dur, input bit clr);
        @(posedge clk); #1;
        i_rec_req = 1'b1;
        i_note_in = NOTE_W'(note);
        i_dur_in  = DUR_W'(dur);
        i_clear   = clr;
        if (clr) begin
            m_count = 0;
        end else if (m_count < CAP) begin
            wq.push_back('{m_count, (dur << NOTE_W) | note});
            m_note[m_count] = note;
            m_dur[m_count] = dur;
            m_count++;
            exp_we++;
        end
        @(posedge clk); #1;
        i_rec_req = 1'b0;
        i_clear   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (tq.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk(nm, tq.size(), 0);
    endtask

    task automatic play(input bit lp, input int stop_at, input int inj_at);
        @(posedge clk); #1;
        i_play_start = 1'b1;
        i_loop_en = lp;
        build(lp, (stop_at >= 0) ? stop_at + 1 : -1);
        if (inj_at >= 0) begin
            fork
                begin
                    repeat (inj_at) @(posedge clk);
                    #1;
                    i_rec_req = 1'b1;
                    i_clear = 1'b1;
                    i_play_start = 1'b1;
                    @(posedge clk); #1;
                    i_rec_req = 1'b0;
                    i_clear = 1'b0;
                    i_play_start = 1'b0;
                end
            join_none
        end
        @(posedge clk); #1;
        i_play_start = 1'b0;
        if (stop_at >= 0) begin
            repeat (stop_at) @(posedge clk);
            #1 i_play_stop = 1'b1;
            @(posedge clk); #1;
            i_play_stop = 1'b0;
        end
        drain("play_drain");
        @(negedge clk);
        chk("end_busy", int'(o_busy), 0);
        chk("end_tone_en", int'(o_tone_en), 0);
        chk("end_play_idx", int'(o_play_idx), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_tone_en", int'(o_tone_en), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_count", int'(o_note_count), 0);
        chk("rst_idx", int'(o_play_idx), 0);
        chk("rst_full", int'(o_full), 0);
        chk("rst_tone_note", int'(o_tone_note), 0);

        @(posedge clk); #1 i_play_start = 1'b1;
        @(posedge clk); #1 i_play_start = 1'b0;
        @(negedge clk);
        chk("empty_play_busy", int'(o_busy), 0);

        rec(5, 1, 0);
        rec(9, 2, 0);
        rec(3, 0, 0);
        @(posedge clk); #1;
        chk("count3", int'(o_note_count), 3);
        chk("rec_busy", int'(o_busy), 0);

        play(0, -1, 10);
        chk("count_after_inject", int'(o_note_count), 3);

        play(1, 25, -1);

        rec(7, 3, 1);
        @(posedge clk); #1;
        chk("clear_count", int'(o_note_count), 0);

        for (int i = 0; i < 5; i++) begin
            rec($urandom_range(0, 15), $urandom_range(0, 7), 0);
            @(posedge clk); #1;
            if (i == 2) chk("full_at3", int'(o_full), 0);
            if (i == 3) chk("full_at4", int'(o_full), 1);
        end
        chk("count_full", int'(o_note_count), 4);

        play(0, -1, -1);

        @(posedge clk); #1;
        i_play_start = 1'b1;
        i_loop_en = 1'b1;
        build(1, 400);
        @(posedge clk); #1 i_play_start = 1'b0;
        n = 0;
        while (!o_tone_en && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("reach_hold", int'(o_tone_en), 1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_tone_en", int'(o_tone_en), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_count", int'(o_note_count), 0);
        chk("arst_idx", int'(o_play_idx), 0);
        tq.delete();
        m_count = 0;
        m_last = 0;
        i_loop_en = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(o_busy), 0);

        rec(12, 2, 0);
        @(posedge clk); #1;
        chk("post_rst_count", int'(o_note_count), 1);
        play(0, -1, -1);

        repeat (3) @(posedge clk);
        chk("writes_total", n_we, exp_we);
        chk("writes_pending", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
